// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: E-stage request/response bundle for the
// HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              valid_i;
  logic [4:0]        alucontrol;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              stall_o;
  logic [DATA_W-1:0] result_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output flush, valid_i, alucontrol, src_a, src_b,
    input  stall_o, result_o, hi_o, lo_o
  );

  modport slave (
    input  flush, valid_i, alucontrol, src_a, src_b,
    output stall_o, result_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO registers, 1-cycle mult, 32-cycle divide.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module hilo_muldiv_unit #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b10101;
  localparam logic [4:0] MFHI_CONTROL  = 5'b10110;
  localparam logic [4:0] MFLO_CONTROL  = 5'b10111;

  localparam logic [5:0] ITERS = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic [5:0]          cnt;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   quo, rem, dvs;
  logic                qneg, rneg;

  logic [DATA_W-1:0]   a, b;
  logic                op_mult, op_multu;
  logic                op_div, op_divu;
  logic                op_mthi, op_mtlo;
  logic                is_div, b_nz, go;
  logic                div_go, early;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W:0]     rem_sh, diff;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign a        = bus.src_a;
  assign b        = bus.src_b;
  assign op_mult  = bus.alucontrol == MULT_CONTROL;
  assign op_multu = bus.alucontrol == MULTU_CONTROL;
  assign op_div   = bus.alucontrol == DIV_CONTROL;
  assign op_divu  = bus.alucontrol == DIVU_CONTROL;
  assign op_mthi  = bus.alucontrol == MTHI_CONTROL;
  assign op_mtlo  = bus.alucontrol == MTLO_CONTROL;
  assign is_div   = op_div | op_divu;
  assign b_nz     = |b;

  assign go     = bus.valid_i & ~bus.flush
                & (state == IDLE);
  assign div_go = go & is_div & b_nz;

  // DIV works on magnitudes; DIVU keeps raw operands.
  assign abs_a = (op_div & a[DATA_W-1]) ? -a : a;
  assign abs_b = (op_div & b[DATA_W-1]) ? -b : b;

`ifdef DIV_EARLY_OUT_EN
  assign early = abs_a < abs_b;
`else
  assign early = 1'b0;
`endif

  // Low 2W bits of the sign-extended product equal the signed product.
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a}
                * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a}
                * {{DATA_W{1'b0}}, b};

  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  assign quo_fix = qneg ? -quo : quo;
  assign rem_fix = rneg ? -rem : rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (div_go) state_n = early ? DONE : BUSY;
      BUSY: if (cnt == 6'd1) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  // Divider datapath: operand latch, then one restoring step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (div_go) begin
      cnt  <= ITERS;
      quo  <= early ? '0 : abs_a;
      rem  <= early ? abs_a : '0;
      dvs  <= abs_b;
      qneg <= op_div & (a[DATA_W-1] ^ b[DATA_W-1]);
      rneg <= op_div & a[DATA_W-1];
    end else if (state == BUSY) begin
      cnt <= cnt - 6'd1;
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= rem_sh[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Architectural HI/LO writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= HILO_RST;
      lo <= HILO_RST;
    end else if (state == DONE && !bus.flush) begin
      hi <= rem_fix;
      lo <= quo_fix;
    end else if (go) begin
      unique case (1'b1)
        op_mult:  {hi, lo} <= prod_s;
        op_multu: {hi, lo} <= prod_u;
        op_mthi:  hi <= a;
        op_mtlo:  lo <= a;
        default:  ;
      endcase
    end
  end

  // Stall while accepting a divide and during iterations.
  always_comb begin
    bus.stall_o = ~bus.flush
                & (div_go | (state == BUSY));
  end

  // MFHI/MFLO read port.
  always_comb begin
    bus.result_o = '0;
    if (bus.alucontrol == MFHI_CONTROL)
      bus.result_o = hi;
    else if (bus.alucontrol == MFLO_CONTROL)
      bus.result_o = lo;
  end

  assign bus.hi_o = hi;
  assign bus.lo_o = lo;

endmodule
